pc_sequencer: RTL

//   Multi-cycle control sequencer and program counter for the RV32I core.

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer_next_pc_calc.sv | 33 +++
 rtl/pc_sequencer.sv | 91 +++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared core definitions: multi-cycle state encodings and PC constants.
// Used by the sequencer, the branch comparator and the decoder.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] JALR_MASK  = ~32'h1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer <-> core bundle: fetch/data handshakes, decode flags, PC.
// master = sequencer side, slave = datapath/memory side.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        imem_ready;
    logic        ir_we;
    logic        is_load;
    logic        is_store;
    logic        dmem_ready;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        taken_branch;
    logic [31:0] rs1_val;
    logic [31:0] imm;
    logic        retire;
    logic        trap;

    modport master (
        output state, pc, pc_plus4, imem_req, ir_we, retire, trap,
        input  imem_ready, is_load, is_store, dmem_ready,
        input  is_branch, is_jal, is_jalr, taken_branch, rs1_val, imm
    );

    modport slave (
        input  state, pc, pc_plus4, imem_req, ir_we, retire, trap,
        output imem_ready, is_load, is_store, dmem_ready,
        output is_branch, is_jal, is_jalr, taken_branch, rs1_val, imm
    );

endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC target and misaligned-redirect detection.
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_val_i,
    input  logic [31:0] imm_i,
    input  logic        is_branch_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic        taken_i,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic redirect;

    always_comb begin
        target_o = pc_i + PC_STEP;
        redirect = 1'b0;
        if (is_jalr_i) begin
            target_o = (rs1_val_i + imm_i) & JALR_MASK;
            redirect = 1'b1;
        end else if (is_jal_i || (is_branch_i && taken_i)) begin
            target_o = pc_i + imm_i;
            redirect = 1'b1;
        end
    end

    // Fall-through is never checked, so a wrap to 0 cannot trap.
    assign misaligned_o = redirect & target_o[1];

endmodule

// File: rtl/pc_sequencer.sv
// Five-state multi-cycle control FSM and program counter for the RV32I core.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.master  bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ir_we_q, ir_we_d;
    logic        retire_q, retire_d;
    logic        trap_q, trap_d;
    logic [31:0] target;
    logic        misaligned;

    next_pc_calc u_next_pc (
        .pc_i         (pc_q),
        .rs1_val_i    (bus.rs1_val),
        .imm_i        (bus.imm),
        .is_branch_i  (bus.is_branch),
        .is_jal_i     (bus.is_jal),
        .is_jalr_i    (bus.is_jalr),
        .taken_i      (bus.taken_branch),
        .target_o     (target),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_we_q  <= 1'b0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_we_q  <= ir_we_d;
            retire_q <= retire_d;
            trap_q   <= trap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_we_d  = 1'b0;
        retire_d = 1'b0;
        trap_d   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    ir_we_d = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_MEM;
            ST_MEM: begin
                if (!(bus.is_load || bus.is_store) || bus.dmem_ready)
                    state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_FETCH;
                if (misaligned) begin
                    pc_d   = TRAP_VEC;
                    trap_d = 1'b1;
                end else begin
                    pc_d     = target;
                    retire_d = 1'b1;
                end
            end
            // Unreachable encodings recover without touching the PC.
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.state    = state_q;
    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + PC_STEP;
    assign bus.imem_req = (state_q == ST_FETCH);
    assign bus.ir_we    = ir_we_q;
    assign bus.retire   = retire_q;
    assign bus.trap     = trap_q;

endmodule
